// File: rtl/aes_pkg.sv
// Shared AES constants and byte/word helpers used by the key schedule and round datapath.
// Word packing: row 0 is the low byte of each 32-bit column.
package aes_pkg;
   localparam int AES_NR     = 10;
   localparam int AES_KEY_W  = 128;
   localparam int AES_WORD_W = 32;

   localparam logic [7:0] RCON_INIT = 8'h01;

   // GF(2^8) multiply-by-2, reduction polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Row 0 takes the old row 1 because row 0 sits in the low byte.
   function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
      return {w[7:0], w[31:8]};
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) then the affine map.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] m;
      p = 8'h00;
      m = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ m;
         m = xtime(m);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   logic [7:0] sq;
   logic [7:0] inv;

   // a^254 == a^-1 (and maps 0 to 0): accumulate a^2 * a^4 * ... * a^128.
   always_comb begin
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   end
endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted valid/ready handshake.
// All outputs are registered; key_load restarts the schedule and overrides any handshake.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR     = 10,
   parameter int REPLAY = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AES_KEY_W-1:0] key_in,
   input  logic                 key_load,
   input  logic                 rk_ready,
   output logic                 rk_valid,
   output logic [AES_KEY_W-1:0] rk_out,
   output logic [3:0]           rk_round,
   output logic                 done
);
   if (NR != AES_NR) begin : g_nr_check
      $error("aes_key_expand: only NR=10 (AES-128) is supported");
   end

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;
   localparam logic [3:0] LAST   = 4'(AES_NR);

   logic [0:0]            state;
   logic [7:0]            rcon;
   logic [AES_KEY_W-1:0]  key_q;
   logic [AES_WORD_W-1:0] rot_w3;
   logic [AES_WORD_W-1:0] sub_w;
   logic [AES_WORD_W-1:0] t, n0, n1, n2, n3;
   logic [AES_KEY_W-1:0]  next_key;

   assign rot_w3 = rot_word(rk_out[31:0]);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .a (rot_w3[8*g +: 8]),
         .s (sub_w[8*g +: 8])
      );
   end

   assign t        = sub_w ^ {24'h0, rcon};
   assign n0       = rk_out[127:96] ^ t;
   assign n1       = rk_out[95:64]  ^ n0;
   assign n2       = rk_out[63:32]  ^ n1;
   assign n3       = rk_out[31:0]   ^ n2;
   assign next_key = {n0, n1, n2, n3};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rk_valid <= 1'b0;
         rk_out   <= '0;
         rk_round <= '0;
         done     <= 1'b0;
         rcon     <= RCON_INIT;
         key_q    <= '0;
      end else begin
         done <= 1'b0;
         if (key_load) begin
            state    <= ACTIVE;
            key_q    <= key_in;
            rk_out   <= key_in;
            rk_round <= '0;
            rcon     <= RCON_INIT;
            rk_valid <= 1'b1;
         end else if (state == ACTIVE && rk_valid && rk_ready) begin
            if (rk_round == LAST) begin
               done <= 1'b1;
               if (REPLAY != 0) begin
                  rk_round <= '0;
                  rk_out   <= key_q;
                  rcon     <= RCON_INIT;
               end else begin
                  state    <= IDLE;
                  rk_valid <= 1'b0;
               end
            end else begin
               rk_out   <= next_key;
               rk_round <= rk_round + 4'd1;
               rcon     <= xtime(rcon);
            end
         end
      end
   end
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: a byte-level FIPS-197 key expansion model feeds
// expected round keys into queues; negedge monitors compare every presented handshake.
module tb_aes_key_expand;
   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   typedef struct packed {
      logic [3:0]   round;
      logic [127:0] key;
   } exp_t;

   logic         clk, rst;
   logic [127:0] key_in;
   logic         key_load, rk_ready, rk_valid, done;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         r_load, r_ready, r_valid, r_done;
   logic [127:0] r_out;
   logic [3:0]   r_round;

   aes_key_expand #(.NR(10), .REPLAY(0)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .rk_ready(rk_ready),
      .rk_valid(rk_valid), .rk_out(rk_out), .rk_round(rk_round), .done(done)
   );

   aes_key_expand #(.NR(10), .REPLAY(1)) dut_rep (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(r_load), .rk_ready(r_ready),
      .rk_valid(r_valid), .rk_out(r_out), .rk_round(r_round), .done(r_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int r_done_cnt = 0;
   exp_t q[$];
   exp_t rq[$];
   logic [7:0]   sbox [0:255];
   logic [7:0]   rcon_tab [0:9];
   logic [127:0] exp_rk [0:10];
   logic [127:0] seen [0:15];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FIPS byte order (k[0] in the top byte) to the DUT column/row packing.
   function automatic logic [127:0] to_dut(input logic [127:0] f);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[96 - 32*c + 8*r +: 8] = f[120 - 8*(4*c + r) +: 8];
      return o;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox[x] = s;
      end
   endtask

   // Textbook word-array key expansion, result stored in DUT packing per round.
   task automatic expand(input logic [127:0] f);
      logic [7:0]   w [0:43][0:3];
      logic [7:0]   t [0:3];
      logic [127:0] g;
      for (int i = 0; i < 16; i++) w[i/4][i%4] = f[120 - 8*i +: 8];
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
         if (i % 4 == 0) begin
            t[0] = sbox[w[i-1][1]] ^ rcon_tab[i/4 - 1];
            t[1] = sbox[w[i-1][2]];
            t[2] = sbox[w[i-1][3]];
            t[3] = sbox[w[i-1][0]];
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
      end
      for (int r = 0; r <= 10; r++) begin
         g = '0;
         for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
               g[120 - 8*(4*k + j) +: 8] = w[4*r + k][j];
         exp_rk[r] = to_dut(g);
      end
   endtask

   task automatic push_run(input int last);
      for (int r = 0; r <= last; r++) q.push_back({4'(r), exp_rk[r]});
   endtask

   task automatic load(input logic [127:0] f);
      key_in   = to_dut(f);
      key_load = 1'b1;
      step();
      key_load = 1'b0;
   endtask

   task automatic wait_round(input logic [3:0] target);
      int n;
      n = 0;
      while (rk_round !== target && n < 40) begin
         step();
         n++;
      end
      chk("wait_round", 128'(rk_round), 128'(target));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk("done_seen", 128'(done), 128'(1));
   endtask

   logic         hold_prev = 1'b0;
   logic [127:0] prev_out;
   logic [3:0]   prev_round;

   always @(negedge clk) begin
      exp_t e;
      if (hold_prev) begin
         chk("hold_out", rk_out, prev_out);
         chk("hold_round", 128'(rk_round), 128'(prev_round));
      end
      hold_prev  = rk_valid && !rk_ready && !key_load && !rst;
      prev_out   = rk_out;
      prev_round = rk_round;
      if (done) done_cnt++;
      if (rk_valid && rk_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_key_round", 128'(rk_round), 128'hffff);
         end else begin
            e = q.pop_front();
            chk("key_round", 128'(rk_round), 128'(e.round));
            chk("key_value", rk_out, e.key);
            seen[rk_round] = rk_out;
            if (rk_round < 4'd10)
               chk("rcon", 128'(dut.rcon), 128'(rcon_tab[rk_round]));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (r_done) r_done_cnt++;
      if (r_valid && r_ready) begin
         if (rq.size() == 0) begin
            chk("rep_unexpected_round", 128'(r_round), 128'hffff);
         end else begin
            e = rq.pop_front();
            chk("rep_round", 128'(r_round), 128'(e.round));
            chk("rep_value", r_out, e.key);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; key_in = '0; key_load = 1'b0; rk_ready = 1'b0;
      r_load = 1'b0; r_ready = 1'b0;
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      build_sbox();
      repeat (2) step();
      chk("rst_valid", 128'(rk_valid), 128'(0));
      chk("rst_out", rk_out, '0);
      chk("rst_round", 128'(rk_round), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_rep_valid", 128'(r_valid), 128'(0));
      rst = 1'b0;
      step();

      // A.1 key, ready held high
      expand(KEY_A);
      push_run(10);
      rk_ready = 1'b1;
      load(KEY_A);
      chk("load_latency_valid", 128'(rk_valid), 128'(1));
      chk("load_latency_round", 128'(rk_round), 128'(0));
      wait_done(n);
      chk("cycles_to_done", 128'(n), 128'(11));
      chk("idle_after_done", 128'(rk_valid), 128'(0));
      step();
      chk("done_pulse_width", 128'(done), 128'(0));
      chk("done_count_1", 128'(done_cnt), 128'(1));
      chk("a1_round1", seen[1], to_dut(A_R1));
      chk("a1_round10", seen[10], to_dut(A_R10));
      chk("queue_empty_1", 128'(q.size()), 128'(0));

      // same key, random backpressure
      push_run(10);
      rk_ready = 1'b0;
      load(KEY_A);
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         rk_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      chk("random_ready_done", 128'(done), 128'(1));
      step();
      chk("done_count_2", 128'(done_cnt), 128'(2));
      chk("queue_empty_2", 128'(q.size()), 128'(0));

      // reload with key B at round 5 during a handshake
      rk_ready = 1'b1;
      push_run(5);
      load(KEY_A);
      wait_round(4'd5);
      expand(KEY_B);
      push_run(10);
      load(KEY_B);
      chk("abort_round", 128'(rk_round), 128'(0));
      chk("abort_key", rk_out, to_dut(KEY_B));
      wait_done(n);
      step();
      chk("done_count_3", 128'(done_cnt), 128'(3));
      chk("b_round10", seen[10], to_dut(B_R10));
      chk("queue_empty_3", 128'(q.size()), 128'(0));

      // reset at round 7
      expand(KEY_A);
      push_run(7);
      load(KEY_A);
      wait_round(4'd7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", 128'(rk_valid), 128'(0));
      chk("midrst_out", rk_out, '0);
      chk("midrst_round", 128'(rk_round), 128'(0));
      chk("midrst_done", 128'(done), 128'(0));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_no_handshake", 128'(rk_valid), 128'(0));
      end
      chk("done_count_4", 128'(done_cnt), 128'(3));
      chk("queue_empty_4", 128'(q.size()), 128'(0));

      // reload coincident with round-10 acceptance
      push_run(10);
      load(KEY_A);
      wait_round(4'd10);
      expand(KEY_B);
      push_run(10);
      load(KEY_B);
      chk("restart_no_done", 128'(done), 128'(0));
      chk("restart_round", 128'(rk_round), 128'(0));
      wait_done(n);
      step();
      chk("done_count_5", 128'(done_cnt), 128'(4));
      chk("queue_empty_5", 128'(q.size()), 128'(0));

      // REPLAY=1 instance: two identical passes
      expand(KEY_A);
      for (int p = 0; p < 2; p++)
         for (int r = 0; r <= 10; r++) rq.push_back({4'(r), exp_rk[r]});
      key_in  = to_dut(KEY_A);
      r_ready = 1'b1;
      r_load  = 1'b1;
      step();
      r_load = 1'b0;
      n = 0;
      while (r_done !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk("rep_cycles_1", 128'(n), 128'(11));
      chk("rep_wrap_round", 128'(r_round), 128'(0));
      chk("rep_wrap_key", r_out, to_dut(KEY_A));
      chk("rep_wrap_valid", 128'(r_valid), 128'(1));
      step();
      n = 1;
      while (r_done !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk("rep_cycles_2", 128'(n), 128'(11));
      r_ready = 1'b0;
      step();
      chk("rep_done_count", 128'(r_done_cnt), 128'(2));
      chk("rep_queue_empty", 128'(rq.size()), 128'(0));
      chk("rep_still_valid", 128'(r_valid), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
